// File: rtl/universal_shift_register_if.sv
// Bus bundle for universal_shift_register: control/data inputs and register/status outputs.
// The master modport drives the operation; the slave modport is the register itself.
interface universal_shift_register_if #(
  parameter int n = 8
);
  localparam int CW = $clog2(n) + 1;

  logic [2:0]    mode;
  logic          SI_R;
  logic          SI_L;
  logic [n-1:0]  D;
  logic          start;
  logic [CW-1:0] count;
  logic [n-1:0]  Q;
  logic          SO_R;
  logic          SO_L;
  logic          busy;
  logic          done;

  modport master (
    output mode, SI_R, SI_L, D, start, count,
    input  Q, SO_R, SO_L, busy, done
  );

  modport slave (
    input  mode, SI_R, SI_L, D, start, count,
    output Q, SO_R, SO_L, busy, done
  );
endinterface

// File: rtl/universal_shift_register.sv
// n-bit universal shift register (hold/shift/rotate/arith-shift/load/clear) with an optional
// multi-step burst FSM compiled in by defining UNIVERSAL_SHIFT_REGISTER_BURST_EN.
module universal_shift_register #(
  parameter int n = 8
) (
  input logic                      clk,
  input logic                      reset_n,
  universal_shift_register_if.slave bus
);
  localparam int CW = $clog2(n) + 1;

  typedef enum logic [2:0] {
    HOLD  = 3'b000,
    SHR   = 3'b001,
    SHL   = 3'b010,
    LOAD  = 3'b011,
    ROTR  = 3'b100,
    ROTL  = 3'b101,
    ASHR  = 3'b110,
    CLEAR = 3'b111
  } mode_e;

  logic [n-1:0] r_q;
  mode_e        w_mode;

  assign w_mode   = mode_e'(bus.mode);
  assign bus.Q    = r_q;
  assign bus.SO_R = r_q[0];
  assign bus.SO_L = r_q[n-1];

  // One-step next value for any operation; shared by direct execution and burst steps.
  function automatic logic [n-1:0] f_next(input mode_e op, input logic [n-1:0] q,
                                          input logic [n-1:0] d, input logic si_r,
                                          input logic si_l);
    logic [n-1:0] v;
    // NOTE: default-assign before the case so every path defines v and no latch is implied.
    v = q;
    case (op)
      SHR:     v = {si_r, q[n-1:1]};
      SHL:     v = {q[n-2:0], si_l};
      LOAD:    v = d;
      ROTR:    v = {q[0], q[n-1:1]};
      ROTL:    v = {q[n-2:0], q[n-1]};
      ASHR:    v = {q[n-1], q[n-1:1]};
      CLEAR:   v = '0;
      default: v = q;
    endcase
    return v;
  endfunction

`ifdef UNIVERSAL_SHIFT_REGISTER_BURST_EN
  typedef enum logic {IDLE, RUN} state_e;

  localparam logic [CW-1:0] N_MAX = CW'(n);

  state_e        r_state;
  mode_e         r_mode;
  logic [CW-1:0] r_cnt;
  logic          r_busy;
  logic          r_done;
  logic          w_shift_op;
  logic          w_accept;
  logic [CW-1:0] w_cnt_clamped;

  assign w_shift_op    = w_mode inside {SHR, SHL, ROTR, ROTL, ASHR};
  assign w_accept      = bus.start && (bus.count != '0) && w_shift_op;
  assign w_cnt_clamped = (bus.count > N_MAX) ? N_MAX : bus.count;
  assign bus.busy      = r_busy;
  assign bus.done      = r_done;

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_q     <= '0;
      r_state <= IDLE;
      r_mode  <= HOLD;
      r_cnt   <= '0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        IDLE: begin
          if (w_accept) begin
            r_mode  <= w_mode;
            r_cnt   <= w_cnt_clamped;
            r_busy  <= 1'b1;
            r_state <= RUN;
          end else begin
            r_q <= f_next(w_mode, r_q, bus.D, bus.SI_R, bus.SI_L);
          end
        end
        RUN: begin
          r_q   <= f_next(r_mode, r_q, bus.D, bus.SI_R, bus.SI_L);
          r_cnt <= r_cnt - CW'(1);
          if (r_cnt == CW'(1)) begin
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
            r_state <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end
`else
  logic w_unused;

  assign w_unused = &{1'b0, bus.start, bus.count};
  assign bus.busy = 1'b0;
  assign bus.done = 1'b0;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) r_q <= '0;
    else          r_q <= f_next(w_mode, r_q, bus.D, bus.SI_R, bus.SI_L);
  end
`endif

endmodule

// File: tb/tb_universal_shift_register.sv
// Self-checking bench for universal_shift_register (n=8): directed vectors plus random traffic
// compared every edge against a transaction-level reference model; honours UNIVERSAL_SHIFT_REGISTER_BURST_EN.
module tb_universal_shift_register;
  localparam int N  = 8;
  localparam int CW = $clog2(N) + 1;
`ifdef UNIVERSAL_SHIFT_REGISTER_BURST_EN
  localparam bit BURST = 1'b1;
`else
  localparam bit BURST = 1'b0;
`endif

  localparam logic [2:0] M_HOLD  = 3'd0;
  localparam logic [2:0] M_SHR   = 3'd1;
  localparam logic [2:0] M_SHL   = 3'd2;
  localparam logic [2:0] M_LOAD  = 3'd3;
  localparam logic [2:0] M_ROTR  = 3'd4;
  localparam logic [2:0] M_ROTL  = 3'd5;
  localparam logic [2:0] M_ASHR  = 3'd6;
  localparam logic [2:0] M_CLEAR = 3'd7;

  logic clk = 1'b0;
  logic reset_n;

  always #5 clk = ~clk;

  universal_shift_register_if #(.n(N)) bus ();

  universal_shift_register #(.n(N)) dut (
    .clk    (clk),
    .reset_n(reset_n),
    .bus    (bus.slave)
  );

  int errors = 0;
  int checks = 0;

  // Reference model state: register value plus remaining burst steps.
  logic [N-1:0] m_q;
  int           m_left;
  int           m_op;
  bit           m_busy;
  bit           m_done;

  int busy_cyc;
  int dones;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [N-1:0] ref_op(input int op, input logic [N-1:0] q,
                                          input logic [N-1:0] d, input bit sr, input bit sl);
    int v;
    v = int'(q);
    case (op)
      1:       return N'((v / 2) + (sr ? 128 : 0));
      2:       return N'(((v * 2) % 256) + (sl ? 1 : 0));
      3:       return d;
      4:       return N'((v / 2) + (v % 2) * 128);
      5:       return N'(((v * 2) % 256) + v / 128);
      6:       return N'((v / 2) + ((v >= 128) ? 128 : 0));
      7:       return '0;
      default: return q;
    endcase
  endfunction

  task automatic model_edge();
    int op;
    int c;
    op     = int'(bus.mode);
    c      = int'(bus.count);
    m_done = 1'b0;
    if (m_left > 0) begin
      m_q = ref_op(m_op, m_q, bus.D, bus.SI_R, bus.SI_L);
      m_left--;
      m_done = (m_left == 0);
    end else if (BURST && bus.start && c != 0 && (op inside {1, 2, 4, 5, 6})) begin
      m_op   = op;
      m_left = (c > N) ? N : c;
    end else begin
      m_q = ref_op(op, m_q, bus.D, bus.SI_R, bus.SI_L);
    end
    m_busy = (m_left > 0);
  endtask

  task automatic drive(input logic [2:0] md, input logic sr, input logic sl,
                       input logic [N-1:0] d, input logic st, input logic [CW-1:0] cnt);
    bus.mode  = md;
    bus.SI_R  = sr;
    bus.SI_L  = sl;
    bus.D     = d;
    bus.start = st;
    bus.count = cnt;
  endtask

  task automatic tick(input string tag);
    @(posedge clk);
    #1;
    model_edge();
    check({tag, ".q"},    32'(bus.Q),    32'(m_q));
    check({tag, ".so_r"}, 32'(bus.SO_R), 32'(m_q[0]));
    check({tag, ".so_l"}, 32'(bus.SO_L), 32'(m_q[N-1]));
    check({tag, ".busy"}, 32'(bus.busy), 32'(m_busy));
    check({tag, ".done"}, 32'(bus.done), 32'(m_done));
  endtask

  // Asynchronous reset between clock edges; checks the outputs clear before any edge.
  task automatic apply_reset(input string tag);
    #2 reset_n = 1'b0;
    #1;
    m_q = '0; m_left = 0; m_busy = 1'b0; m_done = 1'b0;
    check({tag, ".q"},    32'(bus.Q),    32'h0);
    check({tag, ".busy"}, 32'(bus.busy), 32'h0);
    check({tag, ".done"}, 32'(bus.done), 32'h0);
    #3 reset_n = 1'b1;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset_n = 1'b1;
    m_q = '0; m_left = 0; m_op = 0; m_busy = 1'b0; m_done = 1'b0;
    drive(M_HOLD, 1'b0, 1'b0, '0, 1'b0, '0);
    apply_reset("reset");

    drive(M_LOAD, 1'b0, 1'b0, 8'hA5, 1'b0, '0);
    tick("load_a5");
    check("load_a5.q_const", 32'(bus.Q), 32'hA5);
    check("load_a5.so_r_const", 32'(bus.SO_R), 32'h1);
    check("load_a5.so_l_const", 32'(bus.SO_L), 32'h1);

    drive(M_CLEAR, 1'b0, 1'b0, '0, 1'b0, '0);
    tick("clear");
    drive(M_SHR, 1'b1, 1'b0, '0, 1'b0, '0);
    for (int i = 0; i < 3; i++) tick("shr");
    check("shr3.q_const", 32'(bus.Q), 32'hE0);
    drive(M_SHL, 1'b0, 1'b0, '0, 1'b0, '0);
    for (int i = 0; i < 2; i++) tick("shl");
    check("shl2.q_const", 32'(bus.Q), 32'h80);

    drive(M_LOAD, 1'b0, 1'b0, 8'h81, 1'b0, '0);
    tick("load_81");
    drive(M_ROTL, 1'b0, 1'b0, '0, 1'b0, '0);
    tick("rotl");
    check("rotl.q_const", 32'(bus.Q), 32'h03);
    drive(M_LOAD, 1'b0, 1'b0, 8'h80, 1'b0, '0);
    tick("load_80");
    drive(M_ASHR, 1'b0, 1'b0, '0, 1'b0, '0);
    for (int i = 0; i < 3; i++) tick("ashr");
    check("ashr3.q_const", 32'(bus.Q), 32'hF0);

    drive(M_LOAD, 1'b0, 1'b0, 8'h01, 1'b0, '0);
    tick("load_01");
`ifdef UNIVERSAL_SHIFT_REGISTER_BURST_EN
    drive(M_ROTR, 1'b0, 1'b0, '0, 1'b1, 4'd3);
    tick("rotr_accept");
    check("rotr_accept.q_const", 32'(bus.Q), 32'h01);
    busy_cyc = int'(bus.busy);
    drive(M_HOLD, 1'b0, 1'b0, '0, 1'b0, '0);
    tick("rotr_s1");
    check("rotr_s1.q_const", 32'(bus.Q), 32'h80);
    busy_cyc += int'(bus.busy);
    tick("rotr_s2");
    check("rotr_s2.q_const", 32'(bus.Q), 32'h40);
    busy_cyc += int'(bus.busy);
    tick("rotr_s3");
    check("rotr_s3.q_const", 32'(bus.Q), 32'h20);
    check("rotr_s3.done_const", 32'(bus.done), 32'h1);
    check("rotr_busy_cycles", 32'(busy_cyc), 32'd3);

    // Start presented while done is high must be accepted.
    drive(M_SHL, 1'b0, 1'b1, '0, 1'b1, 4'd1);
    tick("restart_accept");
    check("restart_accept.busy_const", 32'(bus.busy), 32'h1);
    drive(M_HOLD, 1'b0, 1'b0, '0, 1'b0, '0);
    tick("restart_step");
    check("restart_step.q_const", 32'(bus.Q), 32'h41);
    tick("restart_idle");

    drive(M_LOAD, 1'b0, 1'b0, 8'h5A, 1'b0, '0);
    tick("load_5a");
    drive(M_ROTL, 1'b0, 1'b0, '0, 1'b1, 4'd12);
    tick("clamp_accept");
    busy_cyc = int'(bus.busy);
    dones    = 0;
    for (int i = 0; i < 8; i++) begin
      drive(3'($urandom), 1'($urandom), 1'($urandom), 8'($urandom), 1'b1, 4'($urandom));
      tick("clamp_run");
      busy_cyc += int'(bus.busy);
      dones    += int'(bus.done);
    end
    drive(M_HOLD, 1'b0, 1'b0, '0, 1'b0, '0);
    tick("clamp_after");
    dones += int'(bus.done);
    check("clamp.q_const", 32'(bus.Q), 32'h5A);
    check("clamp_busy_cycles", 32'(busy_cyc), 32'd8);
    check("clamp_done_pulses", 32'(dones), 32'd1);

    drive(M_LOAD, 1'b0, 1'b0, 8'h0F, 1'b0, '0);
    tick("load_0f");
    drive(M_SHR, 1'b1, 1'b0, '0, 1'b1, 4'd5);
    tick("abort_accept");
    drive(M_HOLD, 1'b1, 1'b0, '0, 1'b0, '0);
    tick("abort_s1");
    tick("abort_s2");
    apply_reset("abort_reset");
    dones = 0;
    for (int i = 0; i < 6; i++) begin
      tick("abort_after");
      dones += int'(bus.done);
    end
    check("abort_done_pulses", 32'(dones), 32'd0);
`else
    drive(M_ROTR, 1'b0, 1'b0, '0, 1'b1, 4'd3);
    tick("nb_start");
    check("nb_start.q_const", 32'(bus.Q), 32'h80);
    check("nb_start.busy_const", 32'(bus.busy), 32'h0);
    check("nb_start.done_const", 32'(bus.done), 32'h0);
`endif

    for (int i = 0; i < 400; i++) begin
      drive(3'($urandom), 1'($urandom), 1'($urandom), 8'($urandom),
            1'($urandom_range(3) == 0), 4'($urandom_range(15)));
      if ($urandom_range(99) == 0) apply_reset("rand_reset");
      tick("rand");
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/universal_shift_register.md
UNIVERSAL_SHIFT_REGISTER -- requirements
Module: universal_shift_register

Interface
REQ-001 Parameter n SHALL default to 8 and set the register width in bits; legal range n >= 2.
REQ-002 Localparam CW SHALL equal $clog2(n)+1 and set the burst count width.
REQ-003 clk  input  1  SHALL be the single clock; all state SHALL update on its rising edge.
REQ-004 reset_n  input  1  SHALL be an asynchronous, active-low reset.
REQ-005 mode  input  3  SHALL select the operation: 000 HOLD, 001 SHR, 010 SHL, 011 LOAD, 100 ROTR, 101 ROTL, 110 ASHR, 111 CLEAR.
REQ-006 SI_R  input  1  SHALL be the serial bit entering Q[n-1] on SHR.
REQ-007 SI_L  input  1  SHALL be the serial bit entering Q[0] on SHL.
REQ-008 D  input  n  SHALL be the parallel load data.
REQ-009 start  input  1  SHALL request a burst shift.
REQ-010 count  input  CW  SHALL give the number of burst steps.
REQ-011 Q  output  n  SHALL be the registered register contents.
REQ-012 SO_R  output  1  SHALL equal Q[0]; SO_L  output  1  SHALL equal Q[n-1]; both combinational from Q.
REQ-013 busy  output  1  SHALL be registered and high while a burst is running.
REQ-014 done  output  1  SHALL be registered and pulse high for one cycle at burst completion.

Function
REQ-015 Single-step ops per edge: SHR Q<={SI_R,Q[n-1:1]}; SHL Q<={Q[n-2:0],SI_L}; LOAD Q<=D; ROTR Q<={Q[0],Q[n-1:1]}; ROTL Q<={Q[n-2:0],Q[n-1]}; ASHR Q<={Q[n-1],Q[n-1:1]}; CLEAR Q<=0; HOLD Q unchanged.
REQ-016 Burst FSM SHALL have exactly two states, IDLE and RUN.
REQ-017 In IDLE, start=1 with count!=0 and mode in {SHR,SHL,ROTR,ROTL,ASHR} SHALL be accepted: latch mode and count, Q held that cycle, next state RUN, busy=1 from the next edge.
REQ-018 count > n SHALL be clamped to n at acceptance.
REQ-019 In IDLE, start with count=0 or mode in {HOLD,LOAD,CLEAR} SHALL be ignored and mode SHALL execute as a single-step op.
REQ-020 In RUN, each edge SHALL apply the latched op once and decrement the remaining count; SI_R/SI_L SHALL be sampled live every step.
REQ-021 In RUN, mode, D, start and count SHALL be ignored.
REQ-022 The edge performing the final step SHALL set busy=0, done=1 and return to IDLE; done SHALL clear on the following edge.
REQ-023 A burst of k steps SHALL hold busy high for exactly k cycles; a new start SHALL be accepted in the cycle done is high.
REQ-024 With start=0 in IDLE, busy and done SHALL stay 0.

Reset
REQ-025 reset_n=0 SHALL immediately force Q=0, busy=0, done=0, state IDLE, latched mode/count=0, independent of clk.
REQ-026 Reset during RUN SHALL abort the burst with no done pulse.
REQ-027 The first edge after reset_n deasserts SHALL operate normally.

Configuration
REQ-028 Macro UNIVERSAL_SHIFT_REGISTER_BURST_EN defined SHALL compile in the burst FSM per REQ-016..REQ-024.
REQ-029 Macro undefined: start and count SHALL be ignored, busy and done tied to 0, and all single-step ops SHALL be unchanged.

Verification (n=8, macro defined unless stated)
REQ-030 Reset; mode=LOAD, D=8'hA5, 1 edge -> Q=8'hA5, SO_R=1, SO_L=1.
REQ-031 From Q=00: SHR, SI_R=1, 3 edges -> Q=8'hE0; then SHL, SI_L=0, 2 edges -> Q=8'h80.
REQ-032 From Q=8'h81: ROTL 1 edge -> 8'h03; from Q=8'h80: ASHR 3 edges -> 8'hF0.
REQ-033 From Q=8'h01: start, mode=ROTR, count=3 -> busy high 3 cycles, Q 80,40,20, done pulse with Q=8'h20.
REQ-034 From Q=8'h5A: start, mode=ROTL, count=12 -> clamped, busy 8 cycles, final Q=8'h5A, single done; start during RUN ignored.
REQ-035 Reset asserted mid-burst (step 2) -> Q=00, busy=0, done never asserted; macro undefined: start=1 -> busy=0, done=0, mode executes.
